// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the Sysbus requester arbiter.
package sysbus_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;

  localparam int SYSBUS_TAG_W = 13;
  localparam int ARB_BEATS    = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_CNT_W = idx_w(ARB_BEATS);
endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: first set request at or after start, wrapping around.
// Zero latency; no state, so no backpressure of its own.
module arb_pick
  import sysbus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  always_comb begin
    int   j;
    logic found;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!found && reqs[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sysbus_arbiter.sv
// Shares one Sysbus port among NREQ requesters, one transaction in flight; reqcyc one cycle after c_reqcyc.
// Responses are never back-pressured (respack = respcyc); ARB_RR_EN selects round-robin over fixed priority.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = SYSBUS_TAG_W,
  parameter int BEATS  = ARB_BEATS,
  parameter int GW     = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        c_reqcyc,
  input  logic [NREQ*ADDR_W-1:0] c_req,
  input  logic [NREQ*TAG_W-1:0]  c_reqtag,
  output logic [NREQ-1:0]        c_reqack,
  output logic [NREQ-1:0]        c_respcyc,
  output logic [DATA_W-1:0]      c_resp,
  output logic                   reqcyc,
  output logic [ADDR_W-1:0]      req,
  output logic [TAG_W-1:0]       reqtag,
  input  logic                   reqack,
  input  logic                   respcyc,
  input  logic [DATA_W-1:0]      resp,
  output logic                   respack,
  output logic [GW-1:0]          grant,
  output logic                   proto_err
);
  localparam int CNT_W = idx_w(BEATS);

  arb_state_e        state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [NREQ-1:0]   pick_oh;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     pick_start;
  logic [ADDR_W-1:0] sel_addr;
  logic [TAG_W-1:0]  sel_tag;
  logic              last_beat;
  logic              arb_fire;

  assign arb_fire = (state == ARB_IDLE) && (|c_reqcyc);

`ifdef ARB_RR_EN
  // Starts at NREQ-1 so the first search begins at port 0.
  logic [GW-1:0] last_owner;
  always_ff @(posedge clk) begin
    if (reset)         last_owner <= GW'(NREQ - 1);
    else if (arb_fire) last_owner <= pick_idx;
  end
  assign pick_start = (int'(last_owner) == NREQ - 1) ? '0 : last_owner + GW'(1);
`else
  assign pick_start = '0;
`endif

  arb_pick #(.N(NREQ), .IW(GW)) u_pick (
    .reqs   (c_reqcyc),
    .start  (pick_start),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = c_req[i*ADDR_W +: ADDR_W];
        sel_tag  = c_reqtag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    c_reqack  = '0;
    c_respcyc = '0;
    case (state)
      ARB_IDLE: if (|c_reqcyc) state_nxt = ARB_REQ;
      ARB_REQ: begin
        if (reqack) begin
          c_reqack[grant] = 1'b1;
          state_nxt       = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (respcyc) begin
          c_respcyc[grant] = 1'b1;
          if (last_beat) state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign reqcyc  = (state == ARB_REQ);
  assign respack = respcyc;
  assign c_resp  = resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      req       <= '0;
      reqtag    <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (arb_fire) begin
        grant  <= pick_idx;
        req    <= sel_addr;
        reqtag <= sel_tag;
      end
      if (state == ARB_WAIT && respcyc) beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      // A beat with nothing outstanding is dropped and flagged until reset.
      if (respcyc && state != ARB_WAIT) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Scoreboard bench for sysbus_arbiter: random request rounds vs. a grant-order model, plus directed corner cases.
module tb_sysbus_arbiter;
  localparam int NREQ = 2, ADDR_W = 64, DATA_W = 64, TAG_W = 13, BEATS = 8, GW = 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        c_reqcyc, c_reqack, c_respcyc;
  logic [NREQ*ADDR_W-1:0] c_req;
  logic [NREQ*TAG_W-1:0]  c_reqtag;
  logic [DATA_W-1:0]      c_resp, resp;
  logic                   reqcyc, reqack, respcyc, respack, proto_err;
  logic [ADDR_W-1:0]      req;
  logic [TAG_W-1:0]       reqtag;
  logic [GW-1:0]          grant;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset), .c_reqcyc(c_reqcyc), .c_req(c_req), .c_reqtag(c_reqtag),
    .c_reqack(c_reqack), .c_respcyc(c_respcyc), .c_resp(c_resp), .reqcyc(reqcyc), .req(req),
    .reqtag(reqtag), .reqack(reqack), .respcyc(respcyc), .resp(resp), .respack(respack),
    .grant(grant), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } exp_req_t;

  exp_req_t          exp_req_q[$];
  logic [DATA_W-1:0] exp_beat_q[$];
  exp_req_t          e_m;
  logic [DATA_W-1:0] d_m;
  logic [NREQ-1:0]   oh_m;
  int  n_chk = 0, n_fail = 0, cyc = 0;
  int  cur_port = 0, beats_seen = 0, last_beat_cyc = 0;
  bit  b2b_armed = 0, beat_live = 0, stray_req = 0, prev_ack = 0;
  int  rr_last = NREQ - 1;
  int  sl_phase = 0, sl_dly = 0, sl_gap = 0, sl_beats = 0;
  logic [NREQ-1:0] ack_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: scoreboard had no entry (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an accept or a response beat.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      beats_seen = 0;
      b2b_armed  = 0;
    end else begin
      chk("respack", respack, respcyc);
      if (reqcyc && b2b_armed) begin
        chk("b2b_gap", cyc - last_beat_cyc, 2);
        b2b_armed = 0;
      end
      if (prev_ack) chk("reqcyc_drop", reqcyc, 0);
      if (reqack && reqcyc) begin
        if (exp_req_q.size() == 0) fail_msg("unexpected_req");
        else begin
          e_m = exp_req_q.pop_front();
          oh_m = '0;
          oh_m[e_m.port] = 1'b1;
          chk("c_reqack", c_reqack, oh_m);
          chk("req", req, e_m.addr);
          chk("reqtag", reqtag, e_m.tag);
          chk("grant", grant, e_m.port);
          cur_port = e_m.port;
        end
      end else chk("c_reqack_idle", c_reqack, 0);
      if (respcyc && beat_live) begin
        if (exp_beat_q.size() == 0) fail_msg("unexpected_beat");
        else begin
          d_m = exp_beat_q.pop_front();
          oh_m = '0;
          oh_m[cur_port] = 1'b1;
          chk("c_respcyc", c_respcyc, oh_m);
          chk("c_resp", c_resp, d_m);
          beats_seen++;
          if (beats_seen == BEATS) begin
            beats_seen    = 0;
            last_beat_cyc = cyc;
            b2b_armed     = (exp_req_q.size() > 0);
          end
        end
      end else if (respcyc) chk("stray_c_respcyc", c_respcyc, 0);
      else chk("c_respcyc_idle", c_respcyc, 0);
    end
    prev_ack = reqack && reqcyc && !reset;
  end

  // Requesters drop c_reqcyc the cycle after their accept pulse.
  initial begin
    forever begin
      @(negedge clk);
      ack_s = c_reqack;
      @(posedge clk); #1;
      c_reqcyc = c_reqcyc & ~ack_s;
    end
  end

  // Sysbus slave: random accept delay, BEATS beats with random gaps.
  initial begin
    reqack = 1'b0; respcyc = 1'b0; resp = '0;
    forever begin
      @(posedge clk); #1;
      reqack = 1'b0; respcyc = 1'b0;
      if (reset) begin
        sl_phase = 0; beat_live = 0; exp_beat_q.delete();
      end else begin
        if (sl_phase == 0) begin
          if (stray_req) begin
            respcyc = 1'b1; resp = {$urandom, $urandom}; stray_req = 0;
          end else if (reqcyc) begin
            sl_dly = $urandom_range(0, 3); sl_phase = 1;
          end
        end
        if (sl_phase == 1) begin
          if (sl_dly == 0) begin
            reqack = 1'b1; sl_phase = 2; sl_beats = 0; sl_gap = $urandom_range(0, 2); beat_live = 1;
          end else sl_dly--;
        end else if (sl_phase == 2) begin
          if (sl_gap > 0) sl_gap--;
          else begin
            respcyc = 1'b1; resp = {$urandom, $urandom}; exp_beat_q.push_back(resp);
            sl_beats++; sl_gap = $urandom_range(0, 2);
            if (sl_beats == BEATS) sl_phase = 3;
          end
        end else if (sl_phase == 3) begin
          beat_live = 0; sl_phase = 0;
        end
      end
    end
  end

  // Reference: every port in the round stays pending until served, so service order
  // is simply ascending index (fixed) or a walk from the last owner (round-robin).
  task automatic issue(input logic [NREQ-1:0] mask, input bit fixed);
    exp_req_t e;
    @(posedge clk); #1;
    if (!fixed) begin
      for (int p = 0; p < NREQ; p++) begin
        c_req[p*ADDR_W +: ADDR_W] = {$urandom, $urandom};
        c_reqtag[p*TAG_W +: TAG_W] = TAG_W'($urandom);
      end
    end
`ifdef ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      int p;
      p = (rr_last + k) % NREQ;
      if (mask[p]) begin
        e.port = p; e.addr = c_req[p*ADDR_W +: ADDR_W]; e.tag = c_reqtag[p*TAG_W +: TAG_W];
        exp_req_q.push_back(e);
        rr_last = p;
      end
    end
`else
    for (int p = 0; p < NREQ; p++) begin
      if (mask[p]) begin
        e.port = p; e.addr = c_req[p*ADDR_W +: ADDR_W]; e.tag = c_reqtag[p*TAG_W +: TAG_W];
        exp_req_q.push_back(e);
      end
    end
`endif
    c_reqcyc = mask;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (exp_req_q.size() == 0) && (exp_beat_q.size() == 0) && (sl_phase == 0) && (c_reqcyc == '0);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for idle, %0d requests pending", name, exp_req_q.size());
    end
  endtask

  initial begin
    bit hit;
    reset = 1'b1; c_reqcyc = '0; c_req = '0; c_reqtag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reqcyc", reqcyc, 0);
    chk("rst_req", req, 0);
    chk("rst_reqtag", reqtag, 0);
    chk("rst_c_reqack", c_reqack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_proto_err", proto_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fetch-only request: one cycle of arbitration latency.
    c_req[0 +: ADDR_W] = 64'h1000;
    c_reqtag[0 +: TAG_W] = 13'h0a5;
    issue(2'b01, 1);
    @(negedge clk);
    chk("t1_reqcyc_n", reqcyc, 0);
    @(negedge clk);
    chk("t1_reqcyc_n1", reqcyc, 1);
    chk("t1_req", req, 64'h1000);
    chk("t1_reqtag", reqtag, 13'h0a5);
    wait_idle("t1");

    // Simultaneous requests, then random rounds.
    issue(2'b11, 0);
    wait_idle("t2");
    for (int r = 0; r < 30; r++) begin
      issue(NREQ'($urandom_range(1, 3)), 0);
      wait_idle("rand");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    chk("no_proto_err", proto_err, 0);

    // Beat while idle: dropped, sticky error.
    @(negedge clk);
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("t5_proto_err", proto_err, 1);
    repeat (6) @(negedge clk);
    chk("t5_proto_err_sticky", proto_err, 1);

    // Reset half-way through the response.
    issue(2'b01, 0);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (beats_seen == 4);
    end
    chk("t6_reached_4_beats", hit, 1);
    @(posedge clk); #1;
    reset = 1'b1; c_reqcyc = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_reqcyc", reqcyc, 0);
    chk("t6_c_respcyc", c_respcyc, 0);
    chk("t6_beat_cnt", dut.beat_cnt, 0);
    chk("t6_grant", grant, 0);
    chk("t6_proto_err", proto_err, 0);
    exp_req_q.delete();
    rr_last = NREQ - 1;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(2'b10, 0);
    wait_idle("t6_after");
    issue(2'b11, 0);
    wait_idle("t6_after2");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
